multicycle_decode: RTL and testbench

//  Moore/Mealy control FSM for the multicycle ARM datapath; successor to the single-cycle decoder.

---
 rtl/mc_ctrl_pkg.sv | 62 ++++++
 rtl/mc_alu_decoder.sv | 56 +++++
 rtl/multicycle_decode.sv | 157 +++++++++++++++
 tb/tb_multicycle_decode.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control path: states, Op classes, ALU codes and class helpers.
// LONG_MUL_EN enables the long-multiply sub-codes (RdLo/RdHi two-write sequence).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_MULEX  = 4'd10,
    S_MULWB  = 4'd11,
    S_MULWB2 = 4'd12
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_ORR  = 4'b0011;
  localparam logic [3:0] ALU_EOR  = 4'b0100;
  localparam logic [3:0] ALU_RSB  = 4'b0101;
  localparam logic [3:0] ALU_BIC  = 4'b0110;
  localparam logic [3:0] ALU_MOV  = 4'b0111;
  localparam logic [3:0] ALU_MVN  = 4'b1000;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_MLA  = 4'b1010;
  localparam logic [3:0] ALU_MLS  = 4'b1011;
  localparam logic [3:0] ALU_LMUL = 4'b1100;
  localparam logic [3:0] ALU_LMLA = 4'b1101;
  localparam logic [3:0] ALU_DIV  = 4'b1110;

  function automatic logic is_long(input logic [1:0] op, input logic [3:0] sel);
`ifdef LONG_MUL_EN
    return (op == OP_MUL) && (sel inside {[4'd3:4'd6]});
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic is_nowrite(input logic [1:0] op, input logic [3:0] cmd);
    return (op == OP_DP) && (cmd[3:2] == 2'b10);
  endfunction

  function automatic logic is_legal_mul(input logic [3:0] sel);
`ifdef LONG_MUL_EN
    return sel <= 4'd8;
`else
    return (sel <= 4'd2) || (sel == 4'd7) || (sel == 4'd8);
`endif
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational Op/cmd decode: ALU operation, flag-write mask, compare-only and long-multiply indications.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] Op,
  input  logic [3:0] cmd,
  output logic [3:0] alu_ctrl,
  output logic [1:0] flag_mask,
  output logic       nowrite,
  output logic       long_op
);

  always_comb begin
    alu_ctrl  = ALU_ADD;
    flag_mask = 2'b11;
    nowrite   = is_nowrite(Op, cmd);
    long_op   = is_long(Op, cmd);
    if (Op == OP_DP) begin
      // Carry-using variants share the plain add/sub codes; carry-in is handled in the datapath.
      unique case (cmd)
        4'b0000: alu_ctrl = ALU_AND;
        4'b0001: alu_ctrl = ALU_EOR;
        4'b0010: alu_ctrl = ALU_SUB;
        4'b0011: alu_ctrl = ALU_RSB;
        4'b0100: alu_ctrl = ALU_ADD;
        4'b0101: alu_ctrl = ALU_ADD;
        4'b0110: alu_ctrl = ALU_SUB;
        4'b0111: alu_ctrl = ALU_RSB;
        4'b1000: alu_ctrl = ALU_AND;
        4'b1001: alu_ctrl = ALU_EOR;
        4'b1010: alu_ctrl = ALU_SUB;
        4'b1011: alu_ctrl = ALU_ADD;
        4'b1100: alu_ctrl = ALU_ORR;
        4'b1101: alu_ctrl = ALU_MOV;
        4'b1110: alu_ctrl = ALU_BIC;
        default: alu_ctrl = ALU_MVN;
      endcase
      if (alu_ctrl inside {ALU_AND, ALU_EOR, ALU_ORR, ALU_MOV, ALU_BIC, ALU_MVN})
        flag_mask = 2'b10;
    end else if (Op == OP_MUL) begin
      case (cmd)
        4'b0000: alu_ctrl = ALU_MUL;
        4'b0001: alu_ctrl = ALU_MLA;
        4'b0010: alu_ctrl = ALU_MLS;
        4'b0011: alu_ctrl = ALU_LMUL;
        4'b0100: alu_ctrl = ALU_LMLA;
        4'b0101: alu_ctrl = ALU_LMUL;
        4'b0110: alu_ctrl = ALU_LMLA;
        4'b0111: alu_ctrl = ALU_DIV;
        4'b1000: alu_ctrl = ALU_DIV;
        default: alu_ctrl = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_decode.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute/memory/writeback plus iterative multiply.
// Build option LONG_MUL_EN adds the long-multiply RdLo/RdHi writeback pair.
module multicycle_decode
  import mc_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       HiSel,
  output logic       Busy,
  output logic       Illegal
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_alu;
  logic [1:0]       dec_mask;
  logic             dec_nowrite;
  logic             dec_long;
  logic             rd_pc;

  assign rd_pc = (Rd == 4'hF);

  mc_alu_decoder u_alu_dec (
    .Op        (Op),
    .cmd       (Funct[4:1]),
    .alu_ctrl  (dec_alu),
    .flag_mask (dec_mask),
    .nowrite   (dec_nowrite),
    .long_op   (dec_long)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_MEM:  state <= S_MEMADR;
            OP_DP:   state <= Funct[5] ? S_EXECI : S_EXECR;
            OP_BR:   state <= S_BRANCH;
            default: begin
              if (is_legal_mul(Funct[4:1])) begin
                state <= S_MULEX;
                cnt   <= CNT_W'(MUL_CYCLES - 1);
              end else begin
                state <= S_FETCH;
              end
            end
          endcase
        end
        S_MEMADR: state <= Funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state <= S_MEMWB;
        S_EXECR,
        S_EXECI:  state <= dec_nowrite ? S_FETCH : S_ALUWB;
        S_MULEX: begin
          if (cnt == '0) state <= S_MULWB;
          else           cnt   <= cnt - 1'b1;
        end
        // dec_long is constant 0 without long-multiply support, so S_MULWB2 is unreachable.
        S_MULWB:  state <= dec_long ? S_MULWB2 : S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    PCWrite    = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    ResultSrc  = 2'd0;
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    HiSel      = 1'b0;
    Busy       = 1'b0;
    Illegal    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcA   = 2'd1;
          ALUSrcB   = 2'd2;
          ResultSrc = 2'd2;
        end
        S_DECODE: begin
          ALUSrcA   = 2'd1;
          ALUSrcB   = 2'd2;
          ResultSrc = 2'd2;
          Illegal   = (Op == OP_MUL) && !is_legal_mul(Funct[4:1]);
        end
        S_MEMADR: ALUSrcB = 2'd1;
        S_MEMRD:  AdrSrc  = 1'b1;
        S_MEMWR: begin
          AdrSrc = 1'b1;
          MemW   = CondEx;
        end
        S_EXECR, S_EXECI: begin
          ALUSrcB    = (state == S_EXECI) ? 2'd1 : 2'd0;
          ALUControl = dec_alu;
          FlagW      = (CondEx && Funct[0]) ? dec_mask : 2'b00;
        end
        S_ALUWB, S_MEMWB: begin
          ResultSrc = (state == S_MEMWB) ? 2'd1 : 2'd0;
          RegW      = CondEx && !rd_pc;
          PCWrite   = CondEx && rd_pc;
        end
        S_BRANCH: begin
          ALUSrcB   = 2'd1;
          ResultSrc = 2'd2;
          PCWrite   = CondEx;
        end
        S_MULEX: begin
          ALUSrcA    = 2'd2;
          ALUControl = dec_alu;
          Busy       = 1'b1;
        end
        S_MULWB: begin
          ALUControl = dec_alu;
          RegW       = CondEx;
        end
`ifdef LONG_MUL_EN
        S_MULWB2: begin
          ALUControl = dec_alu;
          RegW       = CondEx;
          HiSel      = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_decode.sv
// Directed bench for multicycle_decode: per-cycle control-word checks against hand-computed vectors.
module tb_multicycle_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       CondEx;
  logic       IRWrite, AdrSrc, PCWrite, RegW, MemW, HiSel, Busy, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, FlagW;
  logic [3:0] ALUControl;
  logic [19:0] obs;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  multicycle_decode #(.MUL_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .CondEx(CondEx),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .PCWrite(PCWrite), .RegW(RegW), .MemW(MemW),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .FlagW(FlagW), .HiSel(HiSel), .Busy(Busy), .Illegal(Illegal)
  );

  assign obs = {IRWrite, PCWrite, RegW, MemW, FlagW, HiSel, Busy, Illegal, AdrSrc,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl};

  function automatic logic [19:0] ex(input logic ir, pc, rw, mw, input logic [1:0] fw,
                                     input logic hi, bz, il, adr,
                                     input logic [1:0] res, sa, sb, input logic [3:0] alu);
    return {ir, pc, rw, mw, fw, hi, bz, il, adr, res, sa, sb, alu};
  endfunction

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %05h want %05h", tag, got, want);
    end
  endtask

  // One clock cycle: settle, compare, advance to the next falling edge.
  task automatic cyc(input string tag, input logic [19:0] want);
    #1;
    check(tag, obs, want);
    @(negedge clk);
  endtask

  task automatic setin(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                       input logic cx);
    Op = op; Funct = fn; Rd = rd; CondEx = cx;
  endtask

  logic [19:0] e_f, e_d;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    e_f = ex(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'h0);
    e_d = ex(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'h0);
    reset = 1'b1;
    setin(2'b00, 6'b000000, 4'h0, 1'b1);
    repeat (2) @(negedge clk);
    cyc("reset", 20'h0);
    reset = 1'b0;

    setin(2'b00, 6'b001000, 4'h1, 1'b1);
    cyc("add_f", e_f);
    cyc("add_d", e_d);
    cyc("add_x", ex(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'h0));
    cyc("add_wb", ex(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'h0));

    setin(2'b00, 6'b010101, 4'h0, 1'b1);
    cyc("cmp_f", e_f);
    cyc("cmp_d", e_d);
    cyc("cmp_x", ex(0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'h1));

    setin(2'b00, 6'b111001, 4'hF, 1'b1);
    cyc("orrs_f", e_f);
    cyc("orrs_d", e_d);
    cyc("orrs_x", ex(0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 4'h3));
    cyc("orrs_wb", ex(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'h0));

    setin(2'b00, 6'b001001, 4'h2, 1'b0);
    cyc("addnc_f", e_f);
    cyc("addnc_d", e_d);
    cyc("addnc_x", 20'h0);
    cyc("addnc_wb", 20'h0);

    setin(2'b01, 6'b011001, 4'h2, 1'b1);
    cyc("ldr_f", e_f);
    cyc("ldr_d", e_d);
    cyc("ldr_adr", ex(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 4'h0));
    cyc("ldr_rd", ex(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'h0));
    cyc("ldr_wb", ex(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 4'h0));

    setin(2'b01, 6'b011000, 4'h2, 1'b0);
    cyc("strnc_f", e_f);
    cyc("strnc_d", e_d);
    cyc("strnc_adr", ex(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 4'h0));
    cyc("strnc_wr", ex(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'h0));

    setin(2'b01, 6'b011000, 4'h2, 1'b1);
    cyc("str_f", e_f);
    cyc("str_d", e_d);
    cyc("str_adr", ex(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 4'h0));
    cyc("str_wr", ex(0, 0, 0, 1, 2'b00, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'h0));

    setin(2'b11, 6'b000000, 4'h3, 1'b1);
    cyc("mul_f", e_f);
    cyc("mul_d", e_d);
    for (int i = 0; i < 4; i++)
      cyc("mul_ex", ex(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 2'd0, 2'd2, 2'd0, 4'h9));
    cyc("mul_wb", ex(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'h9));

    setin(2'b11, 6'b000110, 4'h4, 1'b1);
    cyc("umull_f", e_f);
`ifdef LONG_MUL_EN
    cyc("umull_d", e_d);
    for (int i = 0; i < 4; i++)
      cyc("umull_ex", ex(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 2'd0, 2'd2, 2'd0, 4'hC));
    cyc("umull_lo", ex(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'hC));
    cyc("umull_hi", ex(0, 0, 1, 0, 2'b00, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'hC));
`else
    cyc("umull_ill", ex(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'd2, 2'd1, 2'd2, 4'h0));
`endif

    setin(2'b11, 6'b011110, 4'h4, 1'b1);
    cyc("ill_f", e_f);
    cyc("ill_d", ex(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'd2, 2'd1, 2'd2, 4'h0));

    setin(2'b11, 6'b001110, 4'h5, 1'b0);
    cyc("div_f", e_f);
    cyc("div_d", e_d);
    for (int i = 0; i < 4; i++)
      cyc("div_ex", ex(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 2'd0, 2'd2, 2'd0, 4'hE));
    cyc("div_wb", ex(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'hE));

    setin(2'b11, 6'b000000, 4'h6, 1'b1);
    cyc("abort_f", e_f);
    cyc("abort_d", e_d);
    cyc("abort_ex1", ex(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 2'd0, 2'd2, 2'd0, 4'h9));
    reset = 1'b1;
    cyc("abort_rst", 20'h0);
    reset = 1'b0;
    setin(2'b10, 6'b100000, 4'hF, 1'b1);
    cyc("b_f", e_f);
    cyc("b_d", e_d);
    cyc("b_br", ex(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'd2, 2'd0, 2'd1, 4'h0));

    setin(2'b10, 6'b100000, 4'hF, 1'b0);
    cyc("bnc_f", e_f);
    cyc("bnc_d", e_d);
    cyc("bnc_br", ex(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'd2, 2'd0, 2'd1, 4'h0));
    cyc("next_f", e_f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
